// File: rtl/wb_gpio_pkg.sv
// Purpose : shared constants and helpers for the wb_gpio_irq register bank.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: default parameters, register byte offsets, byte-lane merge helpers.
package wb_gpio_pkg;

  localparam int          DEF_NUM_IO          = 38;
  localparam logic [31:0] DEF_BASE_ADDR       = 32'h3000_0000;
  localparam int          DEF_DEBOUNCE_CYCLES = 16;

  // Byte offsets inside the 256-byte window. LO = bits 31:0, HI = bits NUM_IO-1:32.
  localparam logic [7:0] OFS_OUT_LO = 8'h00;
  localparam logic [7:0] OFS_OUT_HI = 8'h04;
  localparam logic [7:0] OFS_OEB_LO = 8'h08;
  localparam logic [7:0] OFS_OEB_HI = 8'h0C;
  localparam logic [7:0] OFS_IN_LO  = 8'h10;
  localparam logic [7:0] OFS_IN_HI  = 8'h14;
  localparam logic [7:0] OFS_EN_LO  = 8'h18;
  localparam logic [7:0] OFS_EN_HI  = 8'h1C;
  localparam logic [7:0] OFS_POL_LO = 8'h20;
  localparam logic [7:0] OFS_POL_HI = 8'h24;
  localparam logic [7:0] OFS_STS_LO = 8'h28;
  localparam logic [7:0] OFS_STS_HI = 8'h2C;

  // Replace only the byte lanes selected by sel; other lanes keep old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// Purpose : pad input conditioning - 2-flop synchroniser, optional debounce, edge detect.
// Latency : level = pin_in + 2 cycles (+DEBOUNCE_CYCLES when debounced); rise/fall valid alongside the new level.
// Backpressure: none; free-running every cycle.
// Ports   : clk, rst_n (async active-low), pin_in[NUM_IO] (async pads),
//           level[NUM_IO] conditioned value, rise/fall[NUM_IO] one-cycle edge pulses.
// Macro   : WB_GPIO_IRQ_DEBOUNCE_EN adds a per-pin stability counter after the synchroniser.
module gpio_in_cond #(
  parameter int NUM_IO          = 38,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IO-1:0] pin_in,
  output logic [NUM_IO-1:0] level,
  output logic [NUM_IO-1:0] rise,
  output logic [NUM_IO-1:0] fall
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("gpio_in_cond: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [NUM_IO-1:0] sync_meta;
  logic [NUM_IO-1:0] sync_q;
  logic [NUM_IO-1:0] lvl;
  logic [NUM_IO-1:0] lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pin_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0]     stab_cnt [NUM_IO];
  logic [NUM_IO-1:0] stable_q;

  // The counter only runs while the synchronised level differs from the
  // accepted one; any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < NUM_IO; i++) stab_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[i] <= sync_q[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = stable_q;
`else
  assign lvl = sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_d <= '0;
    else        lvl_d <= lvl;
  end

  assign level = lvl;
  assign rise  = lvl & ~lvl_d;
  assign fall  = ~lvl & lvl_d;

endmodule

// File: rtl/wb_gpio_irq.sv
// Purpose : Wishbone GPIO register bank driving pad out/oeb and a per-pin edge interrupt on user_irq[0].
// Latency : ack one cycle after request; writes land on the ack edge; io_out/io_oeb follow one cycle after ack.
// Backpressure: one transaction in flight; a held request is acked every other cycle; out-of-window never acked.
// Ports   : wb_clk_i/wb_rst_n_i, Wishbone slave wbs_*, io_in/io_out/io_oeb[NUM_IO] pads, user_irq[2:0].
// Macro   : WB_GPIO_IRQ_DEBOUNCE_EN enables input debounce inside gpio_in_cond.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_IO          = DEF_NUM_IO,
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        user_irq
);

  if (NUM_IO < 33 || NUM_IO > 64) begin : g_bad_num_io
    $error("wb_gpio_irq: NUM_IO must be in 33..64");
  end

  // Bus side state
  logic        ack_q;
  logic        we_q;
  logic [7:0]  ofs_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [31:0] rd_dat_q;

  // Register file
  logic [NUM_IO-1:0] out_q, oeb_q, en_q, pol_q, sts_q;
  logic              irq_q;

  // Conditioned inputs
  logic [NUM_IO-1:0] in_lvl, in_rise, in_fall;

  logic              in_win, req, wr_stb;
  logic [31:0]       cur_word, merged;
  logic [NUM_IO-1:0] out_nxt, oeb_nxt, en_nxt, pol_nxt, w1c, sts_set;

  gpio_in_cond #(
    .NUM_IO          (NUM_IO),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_in_cond (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .pin_in (io_in),
    .level  (in_lvl),
    .rise   (in_rise),
    .fall   (in_fall)
  );

  // 32-bit view of a register at a given offset; HI halves are zero-extended.
  function automatic logic [31:0] reg_read(input logic [7:0]        ofs,
                                           input logic [NUM_IO-1:0] r_out,
                                           input logic [NUM_IO-1:0] r_oeb,
                                           input logic [NUM_IO-1:0] r_in,
                                           input logic [NUM_IO-1:0] r_en,
                                           input logic [NUM_IO-1:0] r_pol,
                                           input logic [NUM_IO-1:0] r_sts);
    case (ofs)
      OFS_OUT_LO: return r_out[31:0];
      OFS_OUT_HI: return 32'(r_out[NUM_IO-1:32]);
      OFS_OEB_LO: return r_oeb[31:0];
      OFS_OEB_HI: return 32'(r_oeb[NUM_IO-1:32]);
      OFS_IN_LO:  return r_in[31:0];
      OFS_IN_HI:  return 32'(r_in[NUM_IO-1:32]);
      OFS_EN_LO:  return r_en[31:0];
      OFS_EN_HI:  return 32'(r_en[NUM_IO-1:32]);
      OFS_POL_LO: return r_pol[31:0];
      OFS_POL_HI: return 32'(r_pol[NUM_IO-1:32]);
      OFS_STS_LO: return r_sts[31:0];
      OFS_STS_HI: return 32'(r_sts[NUM_IO-1:32]);
      default:    return '0;
    endcase
  endfunction

  // True when pin bit_idx lives in the half addressed by ofs.
  function automatic logic half_hit(input logic [7:0] ofs,
                                    input int         bit_idx,
                                    input logic [7:0] lo_ofs,
                                    input logic [7:0] hi_ofs);
    return (bit_idx < 32) ? (ofs == lo_ofs) : (ofs == hi_ofs);
  endfunction

  assign in_win = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // ack_q in the term keeps a held request from re-triggering on its own ack cycle.
  assign req    = wbs_cyc_i & wbs_stb_i & ~ack_q & in_win;
  assign wr_stb = ack_q & we_q;

  // Write path: the captured request is applied on the ack cycle. The
  // addressed word is merged by byte lane once, then scattered per pin.
  always_comb begin
    cur_word = reg_read(ofs_q, out_q, oeb_q, in_lvl, en_q, pol_q, sts_q);
    merged   = byte_merge(cur_word, dat_q, sel_q);
    out_nxt  = out_q;
    oeb_nxt  = oeb_q;
    en_nxt   = en_q;
    pol_nxt  = pol_q;
    w1c      = '0;
    sts_set  = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (wr_stb && half_hit(ofs_q, i, OFS_OUT_LO, OFS_OUT_HI)) out_nxt[i] = merged[i%32];
      if (wr_stb && half_hit(ofs_q, i, OFS_OEB_LO, OFS_OEB_HI)) oeb_nxt[i] = merged[i%32];
      if (wr_stb && half_hit(ofs_q, i, OFS_EN_LO,  OFS_EN_HI))  en_nxt[i]  = merged[i%32];
      if (wr_stb && half_hit(ofs_q, i, OFS_POL_LO, OFS_POL_HI)) pol_nxt[i] = merged[i%32];
      w1c[i] = wr_stb & half_hit(ofs_q, i, OFS_STS_LO, OFS_STS_HI)
             & sel_q[(i/8)%4] & dat_q[i%32];
      // POL is used live, so a POL write only changes which future edge counts.
      sts_set[i] = pol_q[i] ? in_fall[i] : in_rise[i];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      ofs_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      rd_dat_q <= '0;
      out_q    <= '0;
      oeb_q    <= '1;
      en_q     <= '0;
      pol_q    <= '0;
      sts_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= req;
      if (req) begin
        we_q  <= wbs_we_i;
        ofs_q <= wbs_adr_i[7:0];
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
      end
      // Read data is only non-zero during the ack cycle.
      rd_dat_q <= (req && !wbs_we_i)
                ? reg_read(wbs_adr_i[7:0], out_q, oeb_q, in_lvl, en_q, pol_q, sts_q)
                : '0;
      out_q <= out_nxt;
      oeb_q <= oeb_nxt;
      en_q  <= en_nxt;
      pol_q <= pol_nxt;
      // Set has priority over a same-cycle W1C.
      sts_q <= (sts_q & ~w1c) | sts_set;
      irq_q <= |(sts_q & en_q);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign user_irq  = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Purpose : directed self-checking bench for wb_gpio_irq.
// Latency : n/a.
// Backpressure: n/a.
module tb_wb_gpio_irq;

  localparam int NUM_IO = 38;
  localparam int DEB    = 16;
`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
  localparam int EXTRA = DEB;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = '0;
  logic [31:0]       adr = '0, wdat = '0;
  logic [31:0]       dat_o;
  logic              ack;
  logic [NUM_IO-1:0] io_in = '0;
  logic [NUM_IO-1:0] io_out, io_oeb;
  logic [2:0]        user_irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_gpio_irq #(
    .NUM_IO          (NUM_IO),
    .BASE_ADDR       (32'h3000_0000),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_dat_o  (dat_o),
    .wbs_ack_o  (ack),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .user_irq   (user_irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transfer. Returns the sampled read data, whether it was acked
  // within budget cycles, and ack/dat_o one cycle after the ack.
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input int budget,
                         output logic [31:0] rdat, output logic acked,
                         output logic ack_after, output logic [31:0] dat_after);
    acked = 1'b0; rdat = '0; ack_after = 1'b0; dat_after = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    for (int c = 0; c < budget && !acked; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rdat  = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack_after = ack;
    dat_after = dat_o;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r, da;
    logic        ak, aa;
    wb_xfer(a, 1'b1, s, d, 8, r, ak, aa, da);
    chk({tag, "_ack"}, 64'(ak), 64'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r, da;
    logic        ak, aa;
    wb_xfer(a, 1'b0, 4'hF, 32'h0, 8, r, ak, aa, da);
    chk({tag, "_ack"}, 64'(ak), 64'd1);
    chk(tag, 64'(r), 64'(exp));
    chk({tag, "_dclr"}, 64'(da), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, da;
    logic        ak, aa, seen;
    logic [3:0]  pat;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oeb_held", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_out", 64'(io_out), 64'd0);
    chk("rst_irq", 64'(user_irq), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    rd("rst_oeb_lo", 32'h3000_0008, 32'hFFFF_FFFF);
    rd("rst_oeb_hi", 32'h3000_000C, 32'h0000_003F);

    // 2: byte-masked writes, one-cycle ack, pad outputs
    wb_xfer(32'h3000_0000, 1'b1, 4'b0011, 32'hA5A5_A5A5, 8, r, ak, aa, da);
    chk("t2_ack", 64'(ak), 64'd1);
    chk("t2_ack_width", 64'(aa), 64'd0);
    chk("t2_io_out", 64'(io_out), 64'h00_0000_A5A5);
    rd("t2_out_lo", 32'h3000_0000, 32'h0000_A5A5);
    wr("t2_out_hi_wr", 32'h3000_0004, 32'hFFFF_FFFF, 4'hF);
    rd("t2_out_hi", 32'h3000_0004, 32'h0000_003F);
    chk("t2_io_out_hi", 64'(io_out), 64'h3F_0000_A5A5);
    wr("t2_oeb_wr", 32'h3000_0008, 32'h0000_0000, 4'b0001);
    chk("t2_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FF00);
    rd("t2_oeb_lo", 32'h3000_0008, 32'hFFFF_FF00);

    // 3a: status sets without IRQ_EN, irq stays low
    io_in[5] = 1'b1;
    repeat (6 + EXTRA) @(posedge clk);
    #1;
    chk("t3_irq_masked", 64'(user_irq), 64'd0);
    rd("t3_sts_lo", 32'h3000_0028, 32'h0000_0020);
    rd("t3_in_lo", 32'h3000_0010, 32'h0000_0020);
    wr("t3_w1c_lo", 32'h3000_0028, 32'h0000_0020, 4'hF);
    rd("t3_sts_lo_clr", 32'h3000_0028, 32'h0000_0000);

    // 3b: enabled rising edge on pin 33
    wr("t3_en_hi", 32'h3000_001C, 32'h0000_0002, 4'hF);
    io_in[33] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5 + EXTRA && !seen; c++) begin
      @(posedge clk); #1;
      if (user_irq[0]) seen = 1'b1;
    end
    chk("t3_irq_set", 64'(seen), 64'd1);
    rd("t3_sts_hi", 32'h3000_002C, 32'h0000_0002);
    rd("t3_in_hi", 32'h3000_0014, 32'h0000_0002);
    wr("t3_w1c_hi", 32'h3000_002C, 32'h0000_0002, 4'hF);
    chk("t3_irq_lag", 64'(user_irq[0]), 64'd1);
    @(posedge clk); #1;
    chk("t3_irq_clr", 64'(user_irq[0]), 64'd0);
    rd("t3_sts_hi_clr", 32'h3000_002C, 32'h0000_0000);

    // 4: POL write makes no edge; set beats a coincident W1C
    io_in[3] = 1'b1;
    repeat (6 + EXTRA) @(posedge clk);
    #1;
    rd("t4_sts_rise", 32'h3000_0028, 32'h0000_0008);
    wr("t4_w1c", 32'h3000_0028, 32'h0000_0008, 4'hF);
    rd("t4_sts_clr", 32'h3000_0028, 32'h0000_0000);
    wr("t4_pol", 32'h3000_0020, 32'h0000_0008, 4'hF);
    rd("t4_pol_noedge", 32'h3000_0028, 32'h0000_0000);
    io_in[3] = 1'b0;
    repeat (EXTRA) @(posedge clk);
    wr("t4_w1c_race", 32'h3000_0028, 32'h0000_0008, 4'hF);
    rd("t4_set_wins", 32'h3000_0028, 32'h0000_0008);

    // 5: decode boundaries
    wb_xfer(32'h3000_0100, 1'b1, 4'hF, 32'hFFFF_FFFF, 10, r, ak, aa, da);
    chk("t5_oow_noack", 64'(ak), 64'd0);
    rd("t5_oow_nowrite", 32'h3000_0000, 32'h0000_A5A5);
    rd("t5_unmapped", 32'h3000_0040, 32'h0000_0000);
    wr("t5_unmapped_wr", 32'h3000_0040, 32'hFFFF_FFFF, 4'hF);
    wr("t5_in_wr", 32'h3000_0010, 32'hFFFF_FFFF, 4'hF);
    rd("t5_in_ro", 32'h3000_0010, 32'h0000_0020);

    // Held request: ack every other cycle
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0008;
    pat = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      pat[c] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("t5_held_ack", 64'(pat), 64'b0101);
    @(posedge clk); #1;

    // Reset during an ack drops it and discards the write
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0000; wdat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("t6_ack_before_rst", 64'(ack), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_ack_dropped", 64'(ack), 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_io_out", 64'(io_out), 64'd0);
    rd("t6_out_lo", 32'h3000_0000, 32'h0000_0000);
    rd("t6_oeb_lo", 32'h3000_0008, 32'hFFFF_FFFF);

`ifdef WB_GPIO_IRQ_DEBOUNCE_EN
    // Debounce: short glitch rejected, long level accepted
    repeat (40) @(posedge clk);
    wr("t7_clr_lo", 32'h3000_0028, 32'hFFFF_FFFF, 4'hF);
    wr("t7_clr_hi", 32'h3000_002C, 32'hFFFF_FFFF, 4'hF);
    io_in[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    io_in[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rd("t7_glitch_in", 32'h3000_0010, 32'h0000_0020);
    rd("t7_glitch_sts", 32'h3000_0028, 32'h0000_0000);
    io_in[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rd("t7_level_in", 32'h3000_0010, 32'h0000_0021);
    rd("t7_level_sts", 32'h3000_0028, 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
